// File: rtl/pipe_pkg.sv
// Shared pipeline package: default stage-register field widths, control-field bit positions
// and small helpers used by the pipeline stage registers.
package pipe_pkg;

    localparam int unsigned PipeCtrlW = 10;
    localparam int unsigned PipeDataW = 111;

    // Control-field bit positions (LSB first); bits 8..9 are spare.
    localparam int unsigned CtrlRegDst   = 0;
    localparam int unsigned CtrlMemRead  = 1;
    localparam int unsigned CtrlMemToReg = 2;
    localparam int unsigned CtrlMemWrite = 3;
    localparam int unsigned CtrlAluSrc   = 4;
    localparam int unsigned CtrlRegWrite = 5;
    localparam int unsigned CtrlAluOpLsb = 6;
    localparam int unsigned CtrlAluOpMsb = 7;

    typedef struct packed {
        logic [1:0] spare;
        logic [1:0] aluop;
        logic       regwrite;
        logic       alusrc;
        logic       memwrite;
        logic       memtoreg;
        logic       memread;
        logic       regdst;
    } ctrl_t;

    function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bundle of a pipeline stage register: upstream input, flush, downstream output.
// The stage itself connects through the slave modport.
interface pipe_stage_reg_if #(
    parameter int unsigned CTRL_W = pipe_pkg::PipeCtrlW,
    parameter int unsigned DATA_W = pipe_pkg::PipeDataW
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg_entry.sv
// One held pipeline entry (valid/ctrl/data). Clear drops the entry and zeroes ctrl so an
// empty entry never presents live control bits; reset zeroes everything.
module pipe_entry import pipe_pkg::*; #(
    parameter int unsigned CTRL_W = PipeCtrlW,
    parameter int unsigned DATA_W = PipeDataW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and bubble-zeroed control.
// Define PIPE_STAGE_SKID_EN for a main+skid pair with registered in_ready.
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int unsigned CTRL_W = PipeCtrlW,
    parameter int unsigned DATA_W = PipeDataW
) (
    input logic             CLK,
    input logic             RST,
    pipe_stage_reg_if.slave bus
);
    logic              in_ready;
    logic              accept;
    logic              retire;
    logic              main_valid;
    logic              main_load;
    logic              main_clear;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] main_ctrl_in;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] main_data_in;

    assign accept = bus.in_valid && in_ready;
    assign retire = main_valid && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_clear;
    logic              main_from_skid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_ready_d, in_ready_q;

    // Flush wins over everything; skid refills main on retirement so there is no empty cycle.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (bus.flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (retire) begin
            if (skid_valid) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clear     = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else begin
                main_clear = 1'b1;
            end
        end else if (accept) begin
            if (main_valid) begin
                skid_load = 1'b1;
            end else begin
                main_load = 1'b1;
            end
        end
        in_ready_d = !((skid_valid && !skid_clear) || skid_load);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign main_ctrl_in = main_from_skid ? skid_ctrl : bus.in_ctrl;
    assign main_data_in = main_from_skid ? skid_data : bus.in_data;

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .ctrl_i  (bus.in_ctrl),
        .data_i  (bus.in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    assign bus.occupancy = occ_count(main_valid, skid_valid);
`else
    assign in_ready     = !main_valid || bus.out_ready;
    assign main_ctrl_in = bus.in_ctrl;
    assign main_data_in = bus.in_data;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        if (bus.flush) begin
            main_clear = 1'b1;
        end else if (accept) begin
            main_load = 1'b1;
        end else if (retire) begin
            main_clear = 1'b1;
        end
    end

    assign bus.occupancy = occ_count(main_valid, 1'b0);
`endif

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (main_load),
        .clear_i (main_clear),
        .ctrl_i  (main_ctrl_in),
        .data_i  (main_data_in),
        .valid_o (main_valid),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.out_data  = main_data;
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 10, width of the control field (regdst, memread, memtoreg, memwrite, alusrc, regwrite, aluop[1:0], 2 spare).
REQ-002 SHALL have parameter DATA_W, default 111, width of the data field (read_data1, read_data2, sign_extended, Rs, Rt, Rd).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream stage holds a valid instruction.
REQ-006 SHALL have port in_ready  output  1  stage accepts the input this cycle.
REQ-007 SHALL have port in_ctrl  input  CTRL_W  control field from the upstream stage.
REQ-008 SHALL have port in_data  input  DATA_W  data field from the upstream stage.
REQ-009 SHALL have port flush  input  1  discard all held and incoming entries (branch or hazard squash).
REQ-010 SHALL have port out_valid  output  1  output entry valid.
REQ-011 SHALL have port out_ready  input  1  downstream stage consumes the output.
REQ-012 SHALL have port out_ctrl  output  CTRL_W  registered control field; all-zero when out_valid=0.
REQ-013 SHALL have port out_data  output  DATA_W  registered data field.
REQ-014 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 SHALL accept an entry when in_valid && in_ready, and SHALL retire an entry when out_valid && out_ready.
REQ-016 SHALL present an accepted entry on out_* exactly 1 cycle after acceptance when the main entry is empty or retiring that cycle.
REQ-017 SHALL hold a main entry and a skid entry; in_ready SHALL equal !skid_valid and SHALL be driven from a register only.
REQ-018 SHALL write the input into skid when the main entry is valid and not retiring; SHALL move skid to main on main retirement, with no empty cycle.
REQ-019 SHALL preserve FIFO order; simultaneous accept and retire with skid full cannot occur (in_ready=0).
REQ-020 SHALL keep out_ctrl and out_data stable while out_valid && !out_ready.
REQ-021 SHALL, on flush, clear both valid bits and zero out_ctrl next cycle; an input accepted in the flush cycle SHALL be dropped; flush SHALL take priority over accept and skid move.
REQ-022 SHALL force out_ctrl to zero whenever out_valid=0 (bubble semantics: no memwrite or regwrite leaks).
REQ-023 SHALL update occupancy as (+1 on accept) (-1 on retire), saturating within 0..2; it is 0 after a flush.

Reset
REQ-024 SHALL, while RST=1 at the clock edge, set out_valid=0, out_ctrl=0, out_data=0, occupancy=0, skid cleared, in_ready=1 from the next cycle.
REQ-025 SHALL give RST priority over flush and all handshakes; reset asserted mid-transfer discards both entries.

Configuration
REQ-026 SHALL compile the skid entry only when macro PIPE_STAGE_SKID_EN is defined (behaviour as REQ-017..REQ-018).
REQ-027 SHALL, without PIPE_STAGE_SKID_EN, hold a single entry with in_ready = !out_valid || out_ready (combinational), occupancy limited to 0..1, and all other requirements unchanged.

Structure
REQ-028 SHALL take the default CTRL_W/DATA_W constants and control-field bit positions from the shared pipeline package (pipe_pkg), shared with the other stage registers.
REQ-029 SHALL instantiate one sub-module, pipe_entry, holding one valid/ctrl/data triple with load and clear; two instances with the skid, one without.

Verification
REQ-030 SHALL check streaming: in_valid=1, out_ready=1, data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later, occupancy=1, in_ready=1 throughout.
REQ-031 SHALL check backpressure: out_ready=0 while sending A,B -> occupancy=2, in_ready=0, out_data=A held; out_ready=1 -> A then B on consecutive cycles, no gap.
REQ-032 SHALL check flush: occupancy=2, out_ctrl=10'h3FF, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, input dropped.
REQ-033 SHALL check reset mid-operation: RST=1 with occupancy=2 -> next cycle all outputs zero, in_ready=1; RST together with flush behaves as reset.
REQ-034 SHALL check the build without PIPE_STAGE_SKID_EN: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, and occupancy never exceeds 1.
